// File: rtl/processor_core.sv
// processor_core: single-cycle 8-bit accumulator CPU with R0-R7, a 256x8 RAM, an 8-deep
// return/data stack and one I/O port. The instruction word comes from an external ROM indexed by PC.
module processor_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [15:0]           INSTR,
  output logic [PC_WIDTH-1:0]   PC,
  input  logic [DATA_WIDTH-1:0] PORTA_IN,
  output logic [DATA_WIDTH-1:0] PORTA_OUT,
  output logic [DATA_WIDTH-1:0] ACC,
  output logic                  ZF
);

  localparam int NUM_REGS    = 8;
  localparam int STACK_DEPTH = 8;
  localparam int RAM_DEPTH   = 1 << DATA_WIDTH;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01000;
  localparam logic [4:0] OP_NOT  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_SHR  = 5'b01011;
  localparam logic [4:0] OP_LDM  = 5'b01100;
  localparam logic [4:0] OP_STM  = 5'b01101;
  localparam logic [4:0] OP_JMP  = 5'b01110;
  localparam logic [4:0] OP_JZ   = 5'b01111;
  localparam logic [4:0] OP_JNZ  = 5'b10000;
  localparam logic [4:0] OP_CALL = 5'b10001;
  localparam logic [4:0] OP_RET  = 5'b10010;
  localparam logic [4:0] OP_PUSH = 5'b10011;
  localparam logic [4:0] OP_POP  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_RST  = 5'b10111;
  localparam logic [4:0] OP_INC  = 5'b11000;
  localparam logic [4:0] OP_DEC  = 5'b11001;

  logic [4:0]            opcode;
  logic [2:0]            reg_idx;
  logic [7:0]            imm;
  logic [PC_WIDTH-1:0]   jump_target;

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  zf_q, zf_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic [3:0]            sp_q, sp_d;
  logic [DATA_WIDTH-1:0] porta_q, porta_d;
  logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d  [NUM_REGS];
  logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q   [RAM_DEPTH];

  logic [NUM_REGS-1:0]   reg_we;
  logic [DATA_WIDTH-1:0] rn;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  stack_full, stack_empty;
  logic [2:0]            top_idx;
  logic [DATA_WIDTH-1:0] stack_top;
  logic                  push_en, pop_en, push_ok;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  acc_wr, ram_we, clr_all;

  assign opcode      = INSTR[15:11];
  assign reg_idx     = INSTR[10:8];
  assign imm         = INSTR[7:0];
  assign jump_target = imm[PC_WIDTH-1:0];

  assign rn          = regs_q[reg_idx];
  assign ram_rdata   = ram_q[rn];
  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign clr_all     = (opcode == OP_RST);

  // An empty stack reads as zero; at SP=8 the 3-bit index wraps to 0 and top_idx lands on entry 7.
  assign stack_full  = (sp_q == 4'd8);
  assign stack_empty = (sp_q == 4'd0);
  assign top_idx     = sp_q[2:0] - 3'd1;
  assign stack_top   = stack_empty ? '0 : stack_q[top_idx];
  assign push_ok     = push_en && !stack_full;

  always_comb begin
    acc_d     = acc_q;
    acc_wr    = 1'b0;
    porta_d   = porta_q;
    pc_d      = pc_inc;
    sp_d      = sp_q;
    ram_we    = 1'b0;
    push_en   = 1'b0;
    pop_en    = 1'b0;
    push_data = acc_q;
    case (opcode)
      OP_LDI:  begin acc_d = DATA_WIDTH'(imm);                  acc_wr = 1'b1; end
      OP_LD:   begin acc_d = rn;                                acc_wr = 1'b1; end
      OP_ADD:  begin acc_d = acc_q + rn;                        acc_wr = 1'b1; end
      OP_SUB:  begin acc_d = acc_q - rn;                        acc_wr = 1'b1; end
      OP_AND:  begin acc_d = acc_q & rn;                        acc_wr = 1'b1; end
      OP_OR:   begin acc_d = acc_q | rn;                        acc_wr = 1'b1; end
      OP_XOR:  begin acc_d = acc_q ^ rn;                        acc_wr = 1'b1; end
      OP_NOT:  begin acc_d = ~acc_q;                            acc_wr = 1'b1; end
      OP_SHL:  begin acc_d = {acc_q[DATA_WIDTH-2:0], 1'b0};     acc_wr = 1'b1; end
      OP_SHR:  begin acc_d = {1'b0, acc_q[DATA_WIDTH-1:1]};     acc_wr = 1'b1; end
      OP_INC:  begin acc_d = acc_q + DATA_WIDTH'(1);            acc_wr = 1'b1; end
      OP_DEC:  begin acc_d = acc_q - DATA_WIDTH'(1);            acc_wr = 1'b1; end
      OP_LDM:  begin acc_d = ram_rdata;                         acc_wr = 1'b1; end
      OP_IN:   begin acc_d = PORTA_IN;                          acc_wr = 1'b1; end
      OP_STM:  ram_we  = 1'b1;
      OP_OUT:  porta_d = acc_q;
      OP_JMP:  pc_d = jump_target;
      OP_JZ:   if (zf_q)  pc_d = jump_target;
      OP_JNZ:  if (!zf_q) pc_d = jump_target;
      OP_CALL: begin
        pc_d      = jump_target;
        push_en   = 1'b1;
        push_data = DATA_WIDTH'(pc_inc);
      end
      OP_RET:  begin pc_d = stack_top[PC_WIDTH-1:0]; pop_en = 1'b1; end
      OP_PUSH: push_en = 1'b1;
      OP_POP:  begin acc_d = stack_top; acc_wr = 1'b1; pop_en = 1'b1; end
      OP_RST:  begin
        acc_d   = '0;
        porta_d = '0;
        pc_d    = '0;
      end
      default: ;
    endcase

    if (push_ok)
      sp_d = sp_q + 4'd1;
    else if (pop_en && !stack_empty)
      sp_d = sp_q - 4'd1;
    if (clr_all)
      sp_d = 4'd0;

    zf_d = acc_wr ? (acc_d == '0) : zf_q;
    if (clr_all)
      zf_d = 1'b0;
  end

  // ST is the only writer of R0-R7: one-hot enable per register from the index field.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      assign reg_we[gi] = (opcode == OP_ST) && (reg_idx == 3'(gi));
      assign regs_d[gi] = clr_all ? '0 : (reg_we[gi] ? acc_q : regs_q[gi]);
    end
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      assign stack_d[gi] = clr_all ? '0 :
                           ((push_ok && (sp_q[2:0] == 3'(gi))) ? push_data : stack_q[gi]);
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc_q   <= '0;
      zf_q    <= 1'b0;
      pc_q    <= '0;
      sp_q    <= 4'd0;
      porta_q <= '0;
      for (int i = 0; i < NUM_REGS; i++)    regs_q[i]  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      acc_q   <= acc_d;
      zf_q    <= zf_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      porta_q <= porta_d;
      for (int i = 0; i < NUM_REGS; i++)    regs_q[i]  <= regs_d[i];
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  // RAM keeps its contents across reset, but a write pending when RESET rises must be dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
    end else if (ram_we) begin
      ram_q[rn] <= acc_q;
    end
  end

  assign PC        = pc_q;
  assign ACC       = acc_q;
  assign ZF        = zf_q;
  assign PORTA_OUT = porta_q;

endmodule

// File: tb/tb_processor_core.sv
// Randomized + directed bench for processor_core: a queue-based instruction-level model predicts
// PC/ACC/ZF/PORTA_OUT after every clock; a monitor pops each prediction and compares.
module tb_processor_core;

  localparam logic [4:0] OP_NOP = 5'd0,  OP_LDI = 5'd1,  OP_LD = 5'd2,   OP_ST = 5'd3;
  localparam logic [4:0] OP_ADD = 5'd4,  OP_SUB = 5'd5,  OP_AND = 5'd6,  OP_OR = 5'd7;
  localparam logic [4:0] OP_XOR = 5'd8,  OP_NOT = 5'd9,  OP_SHL = 5'd10, OP_SHR = 5'd11;
  localparam logic [4:0] OP_LDM = 5'd12, OP_STM = 5'd13, OP_JMP = 5'd14, OP_JZ = 5'd15;
  localparam logic [4:0] OP_JNZ = 5'd16, OP_CALL = 5'd17, OP_RET = 5'd18, OP_PUSH = 5'd19;
  localparam logic [4:0] OP_POP = 5'd20, OP_IN = 5'd21,  OP_OUT = 5'd22, OP_RST = 5'd23;
  localparam logic [4:0] OP_INC = 5'd24, OP_DEC = 5'd25;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] INSTR;
  logic [5:0]  PC;
  logic [7:0]  PORTA_IN;
  logic [7:0]  PORTA_OUT;
  logic [7:0]  ACC;
  logic        ZF;

  logic [15:0] rom [64];
  assign INSTR = rom[PC];

  processor_core #(.DATA_WIDTH(8), .PC_WIDTH(6)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .PC(PC),
    .PORTA_IN(PORTA_IN), .PORTA_OUT(PORTA_OUT), .ACC(ACC), .ZF(ZF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pc;
    int acc;
    int zf;
    int porta;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  bit   rand_in = 1'b0;

  // Architectural model: plain integers, a bounded queue for the stack.
  int m_pc, m_acc, m_zf, m_porta;
  int m_r [8];
  int m_ram [256];
  int m_stack[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input int n, input int imm);
    return {op, n[2:0], imm[7:0]};
  endfunction

  function automatic int model_pop();
    if (m_stack.size() == 0) return 0;
    return m_stack.pop_back();
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_zf = 0; m_porta = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_stack.delete();
  endtask

  task automatic model_step();
    logic [15:0] w;
    int op, n, imm, nxt, res;
    bit wr;
    w   = rom[m_pc];
    op  = int'(w[15:11]);
    n   = int'(w[10:8]);
    imm = int'(w[7:0]);
    nxt = (m_pc + 1) % 64;
    res = 0;
    wr  = 1'b0;
    case (op)
      1:  begin res = imm; wr = 1'b1; end
      2:  begin res = m_r[n]; wr = 1'b1; end
      3:  m_r[n] = m_acc;
      4:  begin res = (m_acc + m_r[n]) % 256; wr = 1'b1; end
      5:  begin res = (m_acc - m_r[n] + 256) % 256; wr = 1'b1; end
      6:  begin res = m_acc & m_r[n]; wr = 1'b1; end
      7:  begin res = m_acc | m_r[n]; wr = 1'b1; end
      8:  begin res = m_acc ^ m_r[n]; wr = 1'b1; end
      9:  begin res = 255 - m_acc; wr = 1'b1; end
      10: begin res = (m_acc * 2) % 256; wr = 1'b1; end
      11: begin res = m_acc / 2; wr = 1'b1; end
      12: begin res = m_ram[m_r[n]]; wr = 1'b1; end
      13: m_ram[m_r[n]] = m_acc;
      14: nxt = imm % 64;
      15: if (m_zf != 0) nxt = imm % 64;
      16: if (m_zf == 0) nxt = imm % 64;
      17: begin
        if (m_stack.size() < 8) m_stack.push_back(nxt);
        nxt = imm % 64;
      end
      18: nxt = model_pop() % 64;
      19: if (m_stack.size() < 8) m_stack.push_back(m_acc);
      20: begin res = model_pop(); wr = 1'b1; end
      21: begin res = int'(PORTA_IN); wr = 1'b1; end
      22: m_porta = m_acc;
      23: begin model_reset(); nxt = 0; end
      24: begin res = (m_acc + 1) % 256; wr = 1'b1; end
      25: begin res = (m_acc + 255) % 256; wr = 1'b1; end
      default: ;
    endcase
    if (wr) begin
      m_acc = res;
      m_zf  = (res == 0) ? 1 : 0;
    end
    m_pc = nxt;
  endtask

  // Called at a falling edge; returns at the falling edge after the n-th executed instruction.
  task automatic step(input int n);
    exp_t e;
    repeat (n) begin
      if (rand_in) PORTA_IN = 8'($urandom);
      model_step();
      e.pc = m_pc; e.acc = m_acc; e.zf = m_zf; e.porta = m_porta;
      exp_q.push_back(e);
      @(negedge CLK);
    end
  endtask

  // Asserts RESET between edges so the outputs must clear without a clock.
  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    chk("rst_pc", int'(PC), 0);
    chk("rst_acc", int'(ACC), 0);
    chk("rst_zf", int'(ZF), 0);
    chk("rst_porta", int'(PORTA_OUT), 0);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        txn++;
        $display("txn %0d pc=%02h acc=%02h zf=%0b out=%02h", txn, PC, ACC, ZF, PORTA_OUT);
        chk("sb_pc", int'(PC), mon_e.pc);
        chk("sb_acc", int'(ACC), mon_e.acc);
        chk("sb_zf", int'(ZF), mon_e.zf);
        chk("sb_porta", int'(PORTA_OUT), mon_e.porta);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PORTA_IN = 8'h00;
    for (int i = 0; i < 256; i++) m_ram[i] = 0;
    clear_rom();
    @(negedge CLK);

    // Reset then a small add/out program.
    rom[0] = enc(OP_LDI, 0, 8'h05);
    rom[1] = enc(OP_ST, 1, 0);
    rom[2] = enc(OP_LDI, 0, 8'h03);
    rom[3] = enc(OP_ADD, 1, 0);
    rom[4] = enc(OP_OUT, 0, 0);
    do_reset();
    step(5);
    chk("add_out", int'(PORTA_OUT), 8'h08);
    chk("add_zf", int'(ZF), 0);
    chk("add_pc", int'(PC), 5);

    // Zero flag and branches.
    clear_rom();
    rom[0]    = enc(OP_LDI, 0, 8'h01);
    rom[1]    = enc(OP_DEC, 0, 0);
    rom[2]    = enc(OP_JZ, 0, 8'h10);
    rom[8'h10] = enc(OP_JNZ, 0, 8'h20);
    do_reset();
    step(3);
    chk("jz_acc", int'(ACC), 0);
    chk("jz_zf", int'(ZF), 1);
    chk("jz_pc", int'(PC), 8'h10);
    step(1);
    chk("jnz_not_taken", int'(PC), 8'h11);

    // Input port and RAM round trip.
    clear_rom();
    rom[0] = enc(OP_IN, 0, 0);
    rom[1] = enc(OP_LDI, 0, 8'h20);
    rom[2] = enc(OP_ST, 2, 0);
    rom[3] = enc(OP_IN, 0, 0);
    rom[4] = enc(OP_STM, 2, 0);
    rom[5] = enc(OP_LDI, 0, 8'h00);
    rom[6] = enc(OP_LDM, 2, 0);
    PORTA_IN = 8'd250;
    do_reset();
    step(7);
    chk("ldm_acc", int'(ACC), 8'hFA);
    chk("ldm_zf", int'(ZF), 0);

    // Call and return, including return on an empty stack.
    clear_rom();
    rom[4]     = enc(OP_CALL, 0, 8'h30);
    rom[8'h30] = enc(OP_RET, 0, 0);
    rom[5]     = enc(OP_RET, 0, 0);
    do_reset();
    step(5);
    chk("call_pc", int'(PC), 8'h30);
    step(1);
    chk("ret_pc", int'(PC), 5);
    step(1);
    chk("ret_empty_pc", int'(PC), 0);

    // Stack overflow and underflow.
    clear_rom();
    for (int k = 1; k <= 9; k++) begin
      rom[2*k-2] = enc(OP_LDI, 0, k);
      rom[2*k-1] = enc(OP_PUSH, 0, 0);
    end
    for (int p = 0; p < 10; p++) rom[18+p] = enc(OP_POP, 0, 0);
    do_reset();
    step(18);
    for (int p = 0; p < 10; p++) begin
      step(1);
      chk("pop_val", int'(ACC), (p < 8) ? 8 - p : 0);
    end
    chk("pop_empty_zf", int'(ZF), 1);

    // RST opcode clears the register file, port and PC.
    clear_rom();
    for (int k = 0; k < 8; k++) begin
      rom[2*k]   = enc(OP_LDI, 0, 8'h11 * (k + 1));
      rom[2*k+1] = enc(OP_ST, k, 0);
    end
    rom[16] = enc(OP_LDI, 0, 8'h55);
    rom[17] = enc(OP_OUT, 0, 0);
    rom[18] = enc(OP_RST, 0, 0);
    do_reset();
    step(18);
    chk("pre_rst_out", int'(PORTA_OUT), 8'h55);
    step(1);
    chk("rst_op_pc", int'(PC), 0);
    chk("rst_op_acc", int'(ACC), 0);
    chk("rst_op_out", int'(PORTA_OUT), 0);
    for (int k = 0; k < 8; k++) rom[k] = enc(OP_LD, k, 0);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("rst_op_reg", int'(ACC), 0);
    end

    // PC wrap from 63.
    clear_rom();
    rom[0] = enc(OP_JMP, 0, 8'h3F);
    do_reset();
    step(1);
    chk("wrap_at63", int'(PC), 63);
    step(1);
    chk("wrap_pc", int'(PC), 0);

    // Random programs; LDM is excluded because RAM content before any store is undefined.
    rand_in = 1'b1;
    repeat (3) begin
      for (int i = 0; i < 64; i++) begin
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == OP_LDM) op = OP_NOP;
        rom[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      do_reset();
      step(120);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor_core.md
PROCESSOR_CORE -- requirements
Module: processor_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, datapath width; only 8 is supported.
REQ-002 Parameter PC_WIDTH, default 6, program address width; only 6 is supported.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 INSTR  input  16  instruction word from external ROM, combinationally addressed by PC.
REQ-006 PC  output  6  program counter, the current instruction address.
REQ-007 PORTA_IN  input  8  input port, sampled by IN.
REQ-008 PORTA_OUT  output  8  registered output port.
REQ-009 ACC  output  8  accumulator value, for observation.
REQ-010 ZF  output  1  registered zero flag.

Function
REQ-011 One instruction SHALL execute per CLK cycle: INSTR[15:11] opcode, INSTR[10:8] register index n, INSTR[7:0] immediate (jump targets use imm[5:0]).
REQ-012 Internal state SHALL be ACC, R0-R7 (8-bit), ZF, 256x8 RAM, 8-entry x 8-bit stack with 4-bit pointer SP (0-8), PC, and PORTA_OUT.
REQ-013 Opcodes: 00000 NOP; 00001 LDI ACC<=imm; 00010 LD ACC<=Rn; 00011 ST Rn<=ACC; 00100 ADD ACC<=ACC+Rn; 00101 SUB ACC<=ACC-Rn; 00110 AND; 00111 OR; 01000 XOR (each ACC op Rn).
REQ-014 Opcodes: 01001 NOT ACC<=~ACC; 01010 SHL ACC<={ACC[6:0],0}; 01011 SHR ACC<={0,ACC[7:1]}; 11000 INC ACC<=ACC+1; 11001 DEC ACC<=ACC-1.
REQ-015 Opcodes: 01100 LDM ACC<=RAM[Rn]; 01101 STM RAM[Rn]<=ACC; 10101 IN ACC<=PORTA_IN; 10110 OUT PORTA_OUT<=ACC.
REQ-016 Opcodes: 01110 JMP; 01111 JZ (jump if ZF=1); 10000 JNZ (jump if ZF=0); 10001 CALL push PC+1 then jump; 10010 RET PC<=pop; 10011 PUSH ACC; 10100 POP ACC<=top; 10111 RST; 11010-11111 SHALL execute as NOP.
REQ-017 Arithmetic SHALL be modulo 256 with no carry flag; ADD 0xFF+0x01=0x00, SUB 0x00-0x01=0xFF.
REQ-018 ZF SHALL be updated to (new ACC==0) by every instruction that writes ACC (LDI, LD, ALU ops, LDM, IN, POP) and held otherwise.
REQ-019 PC SHALL be PC+1 (wrapping 63->0) unless a taken jump, CALL, or RET loads it; a not-taken JZ/JNZ SHALL advance by 1.
REQ-020 CALL SHALL push {2'b00, PC+1} (wrapped); RET SHALL load PC with the popped byte's bits [5:0].
REQ-021 PUSH/CALL with SP=8 SHALL leave the stack unchanged; CALL still jumps.
REQ-022 POP/RET with SP=0 SHALL yield 0x00 and leave SP at 0; POP sets ACC=0, ZF=1; RET sets PC=0.
REQ-023 RAM reads SHALL be combinational; RAM writes SHALL be synchronous; RAM contents SHALL not be cleared by reset.
REQ-024 The register-write decoder SHALL enable exactly one of R0-R7 (index n) only for ST; no other opcode writes R0-R7.
REQ-025 RST opcode SHALL, at the next clock edge, clear ACC, R0-R7, ZF, SP, stack entries, PORTA_OUT, and PC to 0.

Reset
REQ-026 While RESET=1, PC, ACC, R0-R7, ZF, SP, stack entries, and PORTA_OUT SHALL be 0 immediately, without waiting for a clock edge.
REQ-027 The first instruction after RESET deasserts SHALL be fetched from address 0.
REQ-028 RESET asserted mid-instruction SHALL abort that instruction with no partial register, RAM, or port write.

Verification
REQ-029 Reset: assert RESET, then release; program at 0: LDI 0x05; ST R1; LDI 0x03; ADD R1; OUT -> PORTA_OUT=0x08, ZF=0, PC=5.
REQ-030 Zero/branch: LDI 0x01; DEC; JZ 0x10 -> ACC=0, ZF=1, PC=0x10; JNZ with ZF=1 -> PC advances by 1.
REQ-031 Input/RAM: PORTA_IN=250; IN; LDI 0x20; ST R2; IN; STM R2; LDI 0; LDM R2 -> ACC=250 (0xFA).
REQ-032 Call/return: CALL 0x30 at address 4 -> PC=0x30, SP=1; RET -> PC=5, SP=0; RET on empty stack -> PC=0.
REQ-033 Stack bounds: 9 PUSHes of 1..9 then POPs -> pops yield 8..1, then 0x00 with ZF=1; SP never exceeds 8.
REQ-034 RST opcode after loading R0-R7 and PORTA_OUT=0x55 -> next cycle all registers 0, PORTA_OUT=0, PC=0; wrap: NOP at 63 -> PC=0.
